// File: rtl/mmss_display_scanner.sv
// mmss_display_scanner: multiplexed common-anode 4-digit mm:ss display driver with per-frame snapshot and blinking colon
module mmss_display_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLANK_LZ     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       blink_tick,
  input  logic [2:0] minutes_tens,
  input  logic [3:0] minutes_ones,
  input  logic [2:0] seconds_tens,
  input  logic [3:0] seconds_ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [2:0] snap_mt, snap_st;
  logic [3:0] snap_mo, snap_so;
  logic colon_on, wrap, blank;
  logic [3:0] digit, an_d;
  logic [6:0] seg_d;
  logic dp_d;
  always_comb begin
    wrap = cnt == CW'(REFRESH_DIV - 1);
    digit = idx == 2'd0 ? snap_so : idx == 2'd1 ? {1'b0, snap_st} : idx == 2'd2 ? snap_mo : {1'b0, snap_mt};
    blank = !enable || (int'(cnt) < BLANK_CYCLES) || (idx == 2'd3 && BLANK_LZ != 0 && snap_mt == 3'd0);
    an_d = blank ? 4'b1111 : ~(4'b0001 << idx);
    dp_d = !(idx == 2'd2 && colon_on && !blank);
    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase
  end
  // snapshot loads only at the idx 3->0 wrap so a frame never mixes two times
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
      snap_mt <= 3'd0;
      snap_mo <= 4'd0;
      snap_st <= 3'd0;
      snap_so <= 4'd0;
      colon_on <= 1'b0;
      an <= 4'b1111;
      seg <= 7'b1111111;
      dp <= 1'b1;
    end else begin
      an <= an_d;
      seg <= seg_d;
      dp <= dp_d;
      if (enable) begin
        cnt <= wrap ? '0 : cnt + CW'(1);
        if (wrap) idx <= idx + 2'd1;
        if (wrap && idx == 2'd3) begin
          snap_mt <= minutes_tens;
          snap_mo <= minutes_ones;
          snap_st <= seconds_tens;
          snap_so <= seconds_ones;
        end
        if (blink_tick) colon_on <= !colon_on;
      end
    end
  end
endmodule

// File: tb/tb_mmss_display_scanner.sv
// tb_mmss_display_scanner: scoreboard bench; stimulus pushes per-edge expectations, a monitor pops and compares
module tb_mmss_display_scanner;
  localparam int RD = 8, BC = 2;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, blink_tick = 1'b0;
  logic [2:0] minutes_tens = 3'd0, seconds_tens = 3'd0;
  logic [3:0] minutes_ones = 4'd0, seconds_ones = 4'd0;
  logic [3:0] an, an_b;
  logic [6:0] seg, seg_b;
  logic dp, dp_b;
  mmss_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .blink_tick(blink_tick),
    .minutes_tens(minutes_tens), .minutes_ones(minutes_ones),
    .seconds_tens(seconds_tens), .seconds_ones(seconds_ones),
    .an(an), .seg(seg), .dp(dp));
  mmss_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLANK_LZ(0)) dut_nolz (
    .clk(clk), .reset(reset), .enable(enable), .blink_tick(blink_tick),
    .minutes_tens(minutes_tens), .minutes_ones(minutes_ones),
    .seconds_tens(seconds_tens), .seconds_ones(seconds_ones),
    .an(an_b), .seg(seg_b), .dp(dp_b));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an_b;
  } exp_t;
  exp_t sb[$];
  exp_t got;
  int checks = 0, failures = 0;
  int p = 0, last_idx = 0, last_c = 0;
  logic [2:0] m_mt = 3'd0, m_st = 3'd0;
  logic [3:0] m_mo = 4'd0, m_so = 4'd0;
  logic m_colon = 1'b0;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction
  function automatic logic [3:0] sel(input int i);
    return i == 0 ? 4'b1110 : i == 1 ? 4'b1101 : i == 2 ? 4'b1011 : 4'b0111;
  endfunction
  task automatic model_reset();
    p = 0;
    m_mt = 3'd0; m_mo = 4'd0; m_st = 3'd0; m_so = 4'd0;
    m_colon = 1'b0;
    sb.delete();
  endtask
  // frame position p runs 0..4*RD-1; slot = p/RD, in-slot count = p%RD
  task automatic tick();
    exp_t e;
    int i, c;
    logic bl, blb;
    logic [3:0] d;
    i = p / RD;
    c = p % RD;
    d = i == 0 ? m_so : i == 1 ? {1'b0, m_st} : i == 2 ? m_mo : {1'b0, m_mt};
    blb = !enable || c < BC;
    bl = blb || (i == 3 && m_mt == 3'd0);
    e.an = bl ? 4'b1111 : sel(i);
    e.an_b = blb ? 4'b1111 : sel(i);
    e.seg = dec(d);
    e.dp = !(i == 2 && m_colon && !bl);
    sb.push_back(e);
    last_idx = i;
    last_c = c;
    if (enable) begin
      if (p == 4 * RD - 1) begin
        m_mt = minutes_tens; m_mo = minutes_ones; m_st = seconds_tens; m_so = seconds_ones;
      end
      if (blink_tick) m_colon = !m_colon;
      p = (p + 1) % (4 * RD);
    end
    @(posedge clk);
    #2;
  endtask
  task automatic run_to(input int s, input int c);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(last_idx == s && last_c == c) && n < 200);
    if (!(last_idx == s && last_c == c)) begin
      checks++;
      failures++;
      $display("FAIL run_to slot=%0d cnt=%0d not reached within 200 cycles", s, c);
    end
  endtask
  task automatic chk(input string name, input logic [11:0] g, input logic [11:0] x);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, g, x);
    end
  endtask
  task automatic set_in(input logic [2:0] mt, input logic [3:0] mo, input logic [2:0] st, input logic [3:0] so);
    minutes_tens = mt; minutes_ones = mo; seconds_tens = st; seconds_ones = so;
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checks++;
      if ({an, seg, dp, an_b} !== got) begin
        failures++;
        $display("FAIL scan got an=%b seg=%b dp=%b an_b=%b expected an=%b seg=%b dp=%b an_b=%b",
                 an, seg, dp, an_b, got.an, got.seg, got.dp, got.an_b);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_an", 12'(an), 12'(4'b1111));
    chk("reset_seg", 12'(seg), 12'(7'b1111111));
    chk("reset_dp", 12'(dp), 12'(1'b1));
    reset = 1'b0;
    model_reset();
    tick(); tick();
    chk("first_blank", 12'(an), 12'(4'b1111));
    tick();
    chk("first_digit", 12'(an), 12'(4'b1110));
    repeat (37) tick();
    // anti-tear: inputs changed mid-frame must not appear until the next frame
    set_in(3'd1, 4'd2, 3'd3, 4'd4);
    run_to(0, 4);
    run_to(1, 4);
    set_in(3'd5, 4'd9, 3'd5, 4'd9);
    run_to(2, 4);
    chk("tear_d2", 12'(seg), 12'(7'b0100100));
    run_to(3, 4);
    chk("tear_d3", 12'(seg), 12'(7'b1111001));
    chk("tear_an3", 12'(an), 12'(4'b0111));
    run_to(0, 4);
    chk("snap_d0", 12'(seg), 12'(7'b0010000));
    run_to(1, 4);
    chk("snap_d1", 12'(seg), 12'(7'b0010010));
    run_to(2, 4);
    chk("snap_d2", 12'(seg), 12'(7'b0010000));
    run_to(3, 4);
    chk("snap_d3", 12'(seg), 12'(7'b0010010));
    set_in(3'd0, 4'd7, 3'd0, 4'd0);
    run_to(3, 7);
    run_to(0, 4);
    run_to(2, 4);
    chk("lz_d2", 12'(seg), 12'(7'b1111000));
    run_to(3, 4);
    chk("lz_an", 12'(an), 12'(4'b1111));
    chk("nolz_an", 12'(an_b), 12'(4'b0111));
    chk("nolz_seg", 12'(seg_b), 12'(7'b1000000));
    blink_tick = 1'b1;
    tick();
    blink_tick = 1'b0;
    run_to(2, 0);
    chk("colon_blank", 12'(dp), 12'(1'b1));
    run_to(2, 4);
    chk("colon_on", 12'(dp), 12'(1'b0));
    run_to(1, 4);
    blink_tick = 1'b1;
    tick();
    blink_tick = 1'b0;
    run_to(2, 4);
    chk("colon_off", 12'(dp), 12'(1'b1));
    enable = 1'b0;
    blink_tick = 1'b1;
    tick();
    blink_tick = 1'b0;
    chk("dis_an", 12'(an), 12'(4'b1111));
    enable = 1'b1;
    run_to(2, 4);
    chk("dis_blink", 12'(dp), 12'(1'b1));
    set_in(3'd1, 4'd0, 3'd0, 4'd12);
    run_to(3, 7);
    run_to(0, 4);
    chk("dash", 12'(seg), 12'(7'b0111111));
    run_to(1, 4);
    chk("pre_dis", 12'(an), 12'(4'b1101));
    enable = 1'b0;
    tick();
    chk("dis_an2", 12'(an), 12'(4'b1111));
    chk("dis_dp", 12'(dp), 12'(1'b1));
    repeat (3) tick();
    enable = 1'b1;
    tick();
    chk("resume_an", 12'(an), 12'(4'b1101));
    run_to(2, 3);
    // asynchronous reset mid-frame, observed before any clock edge
    reset = 1'b1;
    #1;
    chk("areset_an", 12'(an), 12'(4'b1111));
    chk("areset_seg", 12'(seg), 12'(7'b1111111));
    chk("areset_dp", 12'(dp), 12'(1'b1));
    chk("areset_anb", 12'(an_b), 12'(4'b1111));
    model_reset();
    set_in(3'd5, 4'd9, 3'd5, 4'd9);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    run_to(0, 4);
    chk("zero_snap", 12'(seg), 12'(7'b1000000));
    run_to(3, 4);
    chk("zero_lz", 12'(an), 12'(4'b1111));
    run_to(3, 6);
    blink_tick = 1'b1;
    tick();
    blink_tick = 1'b0;
    run_to(2, 4);
    chk("wrap_blink_seg", 12'(seg), 12'(7'b0010000));
    chk("wrap_blink_dp", 12'(dp), 12'(1'b0));
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
